// File: rtl/io_controller.sv
// Memory-mapped DE-board I/O: LED and 7-segment output registers, plus debounced
// KEY/SW inputs with sticky write-1-to-clear status, decoded from a 32-byte window.

module io_debounce #(
  parameter int unsigned  W       = 4,
  parameter int unsigned  CYCLES  = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] pin_i,
  output logic [W-1:0] db_o,
  output logic [W-1:0] db_d_o
);
  localparam int unsigned      CNT_W   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CYCLES - 1);

  logic [W-1:0]     meta_q, sync_q, last_q, last_d, db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // One counter per group: any bit moving restarts the whole group's count.
  always_comb begin
    last_d = last_q;
    cnt_d  = cnt_q;
    db_d   = db_q;
    if (sync_q != last_q) begin
      cnt_d  = '0;
      last_d = sync_q;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      db_d = sync_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      last_q <= RST_VAL;
      db_q   <= RST_VAL;
      cnt_q  <= '0;
    end else begin
      meta_q <= pin_i;
      sync_q <= meta_q;
      last_q <= last_d;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end

  assign db_o   = db_q;
  assign db_d_o = db_d;
endmodule

module io_controller #(
  parameter int unsigned      DBITS           = 32,
  parameter logic [DBITS-1:0] IO_BASE         = DBITS'(32'hF000_0000),
  parameter int unsigned      DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic             wrtEn,
  input  logic [DBITS-1:0] dataIn,
  output logic [DBITS-1:0] dataOut,
  output logic             ioSel,
  input  logic [9:0]       SW,
  input  logic [3:0]       KEY,
  output logic [9:0]       LEDR,
  output logic [7:0]       LEDG,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3
);
  localparam logic [4:0] OFF_HEX     = 5'h00;
  localparam logic [4:0] OFF_LEDR    = 5'h04;
  localparam logic [4:0] OFF_LEDG    = 5'h08;
  localparam logic [4:0] OFF_KEYDATA = 5'h10;
  localparam logic [4:0] OFF_KEYSTAT = 5'h14;
  localparam logic [4:0] OFF_SWDATA  = 5'h18;
  localparam logic [4:0] OFF_SWSTAT  = 5'h1C;

  logic [15:0] hex_q, hex_d;
  logic [9:0]  ledr_q, ledr_d;
  logic [7:0]  ledg_q, ledg_d;
  logic [3:0]  keystat_q, keystat_d;
  logic [9:0]  swstat_q, swstat_d;
  logic [3:0]  key_raw_db, key_raw_db_d, key_dn, key_dn_d;
  logic [9:0]  sw_db, sw_db_d;
  logic [4:0]  off;
  logic        wr;
  logic        unused_ok;

  // KEY is debounced in pin polarity (released = 1) and inverted to pressed state here.
  io_debounce #(.W(4), .CYCLES(DEBOUNCE_CYCLES), .RST_VAL(4'hF)) u_key_db (
    .clk_i(clk), .rst_ni(reset), .pin_i(KEY), .db_o(key_raw_db), .db_d_o(key_raw_db_d)
  );

  io_debounce #(.W(10), .CYCLES(DEBOUNCE_CYCLES), .RST_VAL(10'h000)) u_sw_db (
    .clk_i(clk), .rst_ni(reset), .pin_i(SW), .db_o(sw_db), .db_d_o(sw_db_d)
  );

  assign key_dn    = ~key_raw_db;
  assign key_dn_d  = ~key_raw_db_d;
  assign ioSel     = (addr[DBITS-1:5] == IO_BASE[DBITS-1:5]);
  assign off       = addr[4:0];
  // Stores are single-cycle with no stall: accepted on any edge where wrtEn & ioSel.
  assign wr        = wrtEn & ioSel;
  assign unused_ok = ^dataIn[DBITS-1:16];

  always_comb begin
    hex_d     = hex_q;
    ledr_d    = ledr_q;
    ledg_d    = ledg_q;
    keystat_d = keystat_q;
    swstat_d  = swstat_q;
    if (wr) begin
      case (off)
        OFF_HEX:     hex_d     = dataIn[15:0];
        OFF_LEDR:    ledr_d    = dataIn[9:0];
        OFF_LEDG:    ledg_d    = dataIn[7:0];
        OFF_KEYSTAT: keystat_d = keystat_q & ~dataIn[3:0];
        OFF_SWSTAT:  swstat_d  = swstat_q & ~dataIn[9:0];
        default:     ;
      endcase
    end
    // Set is applied after clear so a coincident event wins.
    keystat_d = keystat_d | (key_dn_d & ~key_dn);
    swstat_d  = swstat_d | (sw_db_d ^ sw_db);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hex_q     <= '0;
      ledr_q    <= '0;
      ledg_q    <= '0;
      keystat_q <= '0;
      swstat_q  <= '0;
    end else begin
      hex_q     <= hex_d;
      ledr_q    <= ledr_d;
      ledg_q    <= ledg_d;
      keystat_q <= keystat_d;
      swstat_q  <= swstat_d;
    end
  end

  always_comb begin
    dataOut = '0;
    if (ioSel) begin
      case (off)
        OFF_HEX:     dataOut = DBITS'(hex_q);
        OFF_LEDR:    dataOut = DBITS'(ledr_q);
        OFF_LEDG:    dataOut = DBITS'(ledg_q);
        OFF_KEYDATA: dataOut = DBITS'(key_dn);
        OFF_KEYSTAT: dataOut = DBITS'(keystat_q);
        OFF_SWDATA:  dataOut = DBITS'(sw_db);
        OFF_SWSTAT:  dataOut = DBITS'(swstat_q);
        default:     dataOut = '0;
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  assign LEDR = ledr_q;
  assign LEDG = ledg_q;
  assign HEX0 = seg7(hex_q[3:0]);
  assign HEX1 = seg7(hex_q[7:4]);
  assign HEX2 = seg7(hex_q[11:8]);
  assign HEX3 = seg7(hex_q[15:12]);
endmodule
